// File: rtl/ov7670_frame_emulator_if.sv
// OV7670 sensor-side bus: emulated PCLK, VSYNC, HREF and the 8-bit pixel byte.
// The emulator drives it through the master modport; a capture block reads it through slave.
interface ov7670_frame_emulator_if;
    logic       pclk_o;
    logic       vsync_o;
    logic       href_o;
    logic [7:0] data_o;

    modport master (output pclk_o, vsync_o, href_o, data_o);
    modport slave  (input  pclk_o, vsync_o, href_o, data_o);
endinterface

// File: rtl/ov7670_frame_emulator.sv
// Transmit-side OV7670 model emitting RGB444 two-byte pixels with PCLK = clk/2.
// Optional OV7670_EMU_SHORT_LINE_EN adds inject_short to truncate one active line by a pixel.
module ov7670_frame_emulator #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int HBLANK_BYTES = 288,
    parameter int VSYNC_LINES  = 3,
    parameter int VBP_LINES    = 17,
    parameter int VFP_LINES    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [11:0] solid_rgb,
`ifdef OV7670_EMU_SHORT_LINE_EN
    input  logic        inject_short,
`endif
    ov7670_frame_emulator_if.master cam,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int LINE_BYTES = 2 * WIDTH + HBLANK_BYTES;
    localparam int BW         = $clog2(LINE_BYTES);
    localparam int LW         = $clog2(VSYNC_LINES + VBP_LINES + HEIGHT + VFP_LINES + 1);
    localparam int XW         = $clog2(WIDTH);
    localparam int YW         = $clog2(HEIGHT);
    localparam int BAR_PX     = WIDTH / 8;
    localparam int PW         = $clog2(BAR_PX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_ACTIVE,
        S_VFP
    } state_t;

    state_t          state, state_nxt;
    logic            pclk;
    logic [BW-1:0]   byte_cnt;
    logic [LW-1:0]   line_cnt;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [2:0]      bar_idx;
    logic [PW-1:0]   bar_px;
    logic [1:0]      mode_q;
    logic [11:0]     rgb_q;

    logic            tick, line_end, phase_end;
    logic            start_nxt, done_nxt;
    int unsigned     phase_lines;
    logic [BW-1:0]   href_len;
    logic            href;
    logic [11:0]     rgb;
    logic [7:0]      x8;
    logic [4:0]      y5;

    always_comb begin
        phase_lines = 1;
        case (state)
            S_VSYNC:  phase_lines = VSYNC_LINES;
            S_VBP:    phase_lines = VBP_LINES;
            S_ACTIVE: phase_lines = HEIGHT;
            S_VFP:    phase_lines = VFP_LINES;
            default:  phase_lines = 1;
        endcase
        tick      = (state != S_IDLE) && pclk;
        line_end  = tick && (byte_cnt == BW'(LINE_BYTES - 1));
        phase_end = line_end && (line_cnt == LW'(phase_lines - 1));
    end

    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: if (enable) begin
                state_nxt = S_VSYNC;
                start_nxt = 1'b1;
            end
            S_VSYNC:  if (phase_end) state_nxt = S_VBP;
            S_VBP:    if (phase_end) state_nxt = S_ACTIVE;
            S_ACTIVE: if (phase_end) state_nxt = S_VFP;
            S_VFP: if (phase_end) begin
                done_nxt = 1'b1;
                if (enable) begin
                    state_nxt = S_VSYNC;
                    start_nxt = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk        <= 1'b0;
            byte_cnt    <= '0;
            line_cnt    <= '0;
            x           <= '0;
            y           <= '0;
            bar_idx     <= '0;
            bar_px      <= '0;
            mode_q      <= '0;
            rgb_q       <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_start <= start_nxt;
            frame_done  <= done_nxt;
            if (done_nxt) frame_count <= frame_count + 1'b1;
            if (start_nxt) begin
                mode_q <= mode;
                rgb_q  <= solid_rgb;
            end
            // Each byte slot starts with PCLK low, including the first slot after IDLE.
            pclk <= (state != S_IDLE && state_nxt != S_IDLE) ? ~pclk : 1'b0;

            if (start_nxt) y <= '0;
            else if (line_end && state == S_ACTIVE) y <= y + 1'b1;

            if (tick) begin
                if (line_end) begin
                    byte_cnt <= '0;
                    line_cnt <= phase_end ? '0 : line_cnt + 1'b1;
                    x        <= '0;
                    bar_idx  <= '0;
                    bar_px   <= '0;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_cnt[0] && byte_cnt < BW'(2 * WIDTH)) begin
                        x <= x + 1'b1;
                        if (bar_px == PW'(BAR_PX - 1)) begin
                            bar_px  <= '0;
                            bar_idx <= bar_idx + 1'b1;
                        end else begin
                            bar_px <= bar_px + 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef OV7670_EMU_SHORT_LINE_EN
    logic short_req, short_cur, take;

    // The request is consumed as the next active line begins; short_cur marks that line.
    assign take = line_end && (state_nxt == S_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            short_req <= 1'b0;
            short_cur <= 1'b0;
        end else begin
            short_req <= (short_req & ~take) | inject_short;
            if (take)          short_cur <= short_req;
            else if (line_end) short_cur <= 1'b0;
        end
    end

    assign href_len = short_cur ? BW'(2 * WIDTH - 2) : BW'(2 * WIDTH);
`else
    assign href_len = BW'(2 * WIDTH);
`endif

    assign x8 = 8'(x);
    assign y5 = 5'(y);

    always_comb begin
        rgb = 12'h000;
        case (mode_q)
            2'd0: case (bar_idx)
                3'd0:    rgb = 12'hFFF;
                3'd1:    rgb = 12'hFF0;
                3'd2:    rgb = 12'h0FF;
                3'd3:    rgb = 12'h0F0;
                3'd4:    rgb = 12'hF0F;
                3'd5:    rgb = 12'hF00;
                3'd6:    rgb = 12'h00F;
                default: rgb = 12'h000;
            endcase
            2'd1:    rgb = {x8[3:0], y5[3:0], x8[7:4]};
            2'd2:    rgb = rgb_q;
            default: rgb = (x8[4] ^ y5[4]) ? 12'hFFF : 12'h000;
        endcase
    end

    assign href        = (state == S_ACTIVE) && (byte_cnt < href_len);
    assign cam.pclk_o  = pclk;
    assign cam.vsync_o = (state == S_VSYNC);
    assign cam.href_o  = href;
    assign cam.data_o  = !href ? 8'h00 : (byte_cnt[0] ? rgb[7:0] : {4'h0, rgb[11:8]});

endmodule

// File: tb/tb_ov7670_frame_emulator.sv
// Directed bench for ov7670_frame_emulator with a reduced frame geometry.
// Walks reset, bars/ramp/checker/solid frames, enable drop, mid-frame reset and the short-line option.
module tb_ov7670_frame_emulator;

    localparam int W         = 32;
    localparam int H         = 20;
    localparam int HB        = 8;
    localparam int VS        = 1;
    localparam int VB        = 2;
    localparam int VF        = 1;
    localparam int LB        = 2 * W + HB;
    localparam int FRAME_CLK = 2 * (VS + VB + H + VF) * LB;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [11:0] solid_rgb;
`ifdef OV7670_EMU_SHORT_LINE_EN
    logic        inject_short;
`endif
    logic        frame_start;
    logic        frame_done;
    logic [15:0] frame_count;

    ov7670_frame_emulator_if cam ();

    ov7670_frame_emulator #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .HBLANK_BYTES (HB),
        .VSYNC_LINES  (VS),
        .VBP_LINES    (VB),
        .VFP_LINES    (VF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .solid_rgb    (solid_rgb),
`ifdef OV7670_EMU_SHORT_LINE_EN
        .inject_short (inject_short),
`endif
        .cam          (cam.master),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] pix [H][2*W];
    int line_len [H];
    int gap, href_pulses, href_ticks, vs_clks, data_nz, pclk_stall, edge_bad;
    int got_done, inject_pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] px(input int ln, input int xx);
        return {pix[ln][2*xx], pix[ln][2*xx+1]};
    endfunction

    // Follows one frame from frame_start to frame_done, sampling on the falling clk edge.
    task automatic watch_frame(input int drop_line, input int rst_line, input bit inject);
        int n;
        int line;
        int bi;
        logic prev_href, prev_vs, prev_pclk;
        logic [9:0] prev_out;
        n = 0; line = -1; bi = 0;
        prev_href = 1'b0; prev_vs = 1'b0; prev_pclk = 1'b0; prev_out = '0;
        gap = 0; href_pulses = 0; href_ticks = 0; vs_clks = 0; data_nz = 0;
        pclk_stall = 0; edge_bad = 0; got_done = 0; inject_pulses = 0;
        for (int i = 0; i < H; i++) begin
            line_len[i] = 0;
            for (int j = 0; j < 2 * W; j++) pix[i][j] = 8'hEE;
        end
        while (frame_start !== 1'b1 && n < 4 * FRAME_CLK) begin
            @(negedge clk);
            n++;
        end
        check("frame_start_seen", {31'd0, frame_start}, 1);
        check("vsync_at_start", {31'd0, cam.vsync_o}, 1);
        while (gap <= FRAME_CLK + 16) begin
            if (gap > 0 && frame_done === 1'b1) begin
                got_done = 1;
                break;
            end
            if (cam.vsync_o) vs_clks++;
            if (!cam.href_o && cam.data_o != 8'h00) data_nz++;
            if (gap > 0 && cam.pclk_o == prev_pclk) pclk_stall++;
            if (gap > 0 && cam.pclk_o && {cam.vsync_o, cam.href_o, cam.data_o} != prev_out) edge_bad++;
            if (cam.pclk_o) begin
                if (cam.href_o) begin
                    if (!prev_href) begin
                        line++;
                        bi = 0;
                        href_pulses++;
                        if (line == drop_line) enable = 1'b0;
                    end
                    if (line >= 0 && line < H && bi < 2 * W) pix[line][bi] = cam.data_o;
                    bi++;
                    if (line >= 0 && line < H) line_len[line] = bi;
                    href_ticks++;
                end
                prev_href = cam.href_o;
            end
            if (inject && prev_vs && !cam.vsync_o) inject_pulses++;
`ifdef OV7670_EMU_SHORT_LINE_EN
            inject_short = inject && prev_vs && !cam.vsync_o;
`endif
            prev_vs = cam.vsync_o;
            if (line == rst_line && bi == 10) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_bus", {21'd0, cam.pclk_o, cam.vsync_o, cam.href_o, cam.data_o}, 0);
                check("rst_pulses", {30'd0, frame_start, frame_done}, 0);
                check("rst_count", {16'd0, frame_count}, 0);
                return;
            end
            prev_pclk = cam.pclk_o;
            prev_out  = {cam.vsync_o, cam.href_o, cam.data_o};
            @(negedge clk);
            gap++;
        end
    endtask

    task automatic check_frame_timing(input string tag);
        check({tag, "_done"}, got_done, 1);
        check({tag, "_clks"}, gap, FRAME_CLK);
        check({tag, "_vsync_clks"}, vs_clks, 2 * VS * LB);
        check({tag, "_data_blank"}, data_nz, 0);
        check({tag, "_pclk_toggle"}, pclk_stall, 0);
        check({tag, "_stable_on_rise"}, edge_bad, 0);
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        rst = 1'b1; enable = 1'b0; mode = 2'd0; solid_rgb = 12'h000;
`ifdef OV7670_EMU_SHORT_LINE_EN
        inject_short = 1'b0;
`endif
        repeat (4) @(negedge clk);
        check("reset_bus", {21'd0, cam.pclk_o, cam.vsync_o, cam.href_o, cam.data_o}, 0);
        check("reset_pulses", {30'd0, frame_start, frame_done}, 0);
        check("reset_count", {16'd0, frame_count}, 0);

        rst = 1'b0;
        cnt_a = 0; cnt_b = 0;
        repeat (1000) begin
            @(negedge clk);
            if (frame_start) cnt_a++;
            if (cam.pclk_o || cam.vsync_o || cam.href_o) cnt_b++;
        end
        check("idle_no_start", cnt_a, 0);
        check("idle_static", cnt_b, 0);

        // Frame 0: colour bars
        enable = 1'b1;
        watch_frame(-1, -1, 1'b0);
        check_frame_timing("f0");
        check("f0_href_pulses", href_pulses, H);
        check("f0_href_ticks", href_ticks, H * 2 * W);
        check("f0_count", {16'd0, frame_count}, 1);
        check("f0_b2b_start", {31'd0, frame_start}, 1);
        check("bars_px0", {16'd0, px(0, 0)}, 32'h0FFF);
        check("bars_px3", {16'd0, px(0, 3)}, 32'h0FFF);
        check("bars_px4", {16'd0, px(0, 4)}, 32'h0FF0);
        check("bars_px12", {16'd0, px(0, 12)}, 32'h00F0);
        check("bars_px20_y19", {16'd0, px(19, 20)}, 32'h0F00);
        check("bars_px31", {16'd0, px(0, 31)}, 32'h0000);

        // Frame 1 already latched mode 0; the new mode applies from frame 2
        mode = 2'd1;
        watch_frame(-1, -1, 1'b0);
        check("f1_done", got_done, 1);
        check("mode_latched", {16'd0, px(0, 4)}, 32'h0FF0);
        check("f1_count", {16'd0, frame_count}, 2);

        mode = 2'd3;
        watch_frame(-1, -1, 1'b0);
        check("f2_done", got_done, 1);
        check("ramp_0_0", {16'd0, px(0, 0)}, 32'h0000);
        check("ramp_19_5", {16'd0, px(5, 19)}, 32'h0351);
        check("ramp_18_13", {16'd0, px(13, 18)}, 32'h02D1);

        mode = 2'd2;
        solid_rgb = 12'hA5C;
        watch_frame(-1, -1, 1'b0);
        check("f3_done", got_done, 1);
        check("chk_0_0", {16'd0, px(0, 0)}, 32'h0000);
        check("chk_15_15", {16'd0, px(15, 15)}, 32'h0000);
        check("chk_16_0", {16'd0, px(0, 16)}, 32'h0FFF);
        check("chk_0_16", {16'd0, px(16, 0)}, 32'h0FFF);
        check("chk_16_16", {16'd0, px(16, 16)}, 32'h0000);

        watch_frame(-1, -1, 1'b0);
        check_frame_timing("f4");
        cnt_a = 0;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++)
                if (px(i, j) != 16'h0A5C) cnt_a++;
        check("solid_bad_pixels", cnt_a, 0);
        check("f4_count", {16'd0, frame_count}, 5);

        // Frame 5: enable dropped mid-frame, frame still completes
        watch_frame(10, -1, 1'b0);
        check_frame_timing("f5");
        check("f5_href_pulses", href_pulses, H);
        check("f5_count", {16'd0, frame_count}, 6);
        check("f5_no_restart", {31'd0, frame_start}, 0);
        cnt_a = 0; cnt_b = 0;
        repeat (40) begin
            @(negedge clk);
            if (frame_start || frame_done) cnt_a++;
            if (cam.pclk_o || cam.vsync_o || cam.href_o) cnt_b++;
        end
        check("drop_idle_pulses", cnt_a, 0);
        check("drop_idle_static", cnt_b, 0);
        check("drop_count_hold", {16'd0, frame_count}, 6);

        // Reset during active line 7
        enable = 1'b1;
        watch_frame(-1, 7, 1'b0);
        cnt_a = 0;
        repeat (2) begin
            @(negedge clk);
            if (frame_done) cnt_a++;
        end
        check("rst_no_done", cnt_a, 0);
        rst = 1'b0;
        @(negedge clk);
        check("start_after_rst", {31'd0, frame_start}, 1);

        watch_frame(-1, -1, 1'b1);
        check_frame_timing("f6");
        check("inject_pulse", inject_pulses, 1);
        check("f6_count", {16'd0, frame_count}, 1);
`ifdef OV7670_EMU_SHORT_LINE_EN
        check("short_line0", line_len[0], 2 * W - 2);
        check("short_total", href_ticks, H * 2 * W - 2);
`else
        check("short_line0", line_len[0], 2 * W);
        check("short_total", href_ticks, H * 2 * W);
`endif
        check("short_line1", line_len[1], 2 * W);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
